// File: rtl/word_bit_serializer_pkg.sv
// Shared definitions for the word bit serializer: word/select widths and FSM state encodings.
package word_bit_serializer_pkg;

    localparam int WORD_W = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    function automatic logic even_parity(input logic [WORD_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/word_bit_select.sv
// Combinational 16:1 bit select of the held word by the current select index.
module word_bit_select
    import word_bit_serializer_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic              bit_o
);

    assign bit_o = word_i[sel_i];

endmodule

// File: rtl/word_bit_serializer.sv
// Loads a 16-bit word on a ready/load handshake and walks it out one bit per HOLD cycles.
// Optional feature: define SER_PARITY_EN to append one even-parity bit after the data bits.
module word_bit_serializer
    import word_bit_serializer_pkg::*;
#(
    parameter int MSB_FIRST = 0,
    parameter int HOLD      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] din,
    output logic              ready,
    output logic [SEL_W-1:0]  sel,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              done,
    output logic [1:0]        dbg_state_o
);

    // Handshake: a word is taken on any rising edge where load=1 and ready=1;
    // load is ignored whenever ready=0 (SHIFT, PARITY, DONE).

    localparam logic [SEL_W-1:0] SEL_START = (MSB_FIRST != 0) ? 4'd15 : 4'd0;
    localparam logic [SEL_W-1:0] SEL_LAST  = (MSB_FIRST != 0) ? 4'd0  : 4'd15;
    localparam logic [3:0]       HOLD_LAST = 4'(HOLD - 1);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   held_q, held_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [3:0]          hold_q, hold_d;
    logic                sel_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            held_q  <= '0;
            sel_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        sel_d     = sel_q;
        hold_d    = hold_q;
        ready     = 1'b0;
        ser_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (load) begin
                    held_d  = din;
                    sel_d   = SEL_START;
                    hold_d  = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                ser_valid = 1'b1;
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (sel_q == SEL_LAST) begin
                        // sel stays on the last index; it never wraps inside a frame
`ifdef SER_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_DONE;
`endif
                    end else if (MSB_FIRST != 0) begin
                        sel_d = sel_q - 4'd1;
                    end else begin
                        sel_d = sel_q + 4'd1;
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
`ifdef SER_PARITY_EN
            S_PARITY: begin
                ser_valid = 1'b1;
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = S_DONE;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    word_bit_select u_select (
        .word_i (held_q),
        .sel_i  (sel_q),
        .bit_o  (sel_bit)
    );

    assign ser_out     = ser_valid & ((state_q == S_PARITY) ? even_parity(held_q) : sel_bit);
    assign sel         = sel_q;
    assign dbg_state_o = state_q;

endmodule
